// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake and decoded-field bus of the decode stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_op;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm_i;
  logic [XLEN-1:0] out_imm_s;
  logic [XLEN-1:0] out_imm_b;
  logic [XLEN-1:0] out_imm_j;
  logic [XLEN-1:0] out_imm_u;
  logic            out_illegal;

  // Environment side: supplies instructions and downstream back-pressure.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
    input  out_funct3, out_funct7, out_imm_i, out_imm_s, out_imm_b,
    input  out_imm_j, out_imm_u, out_illegal
  );

  // Decode-stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
    output out_funct3, out_funct7, out_imm_i, out_imm_s, out_imm_b,
    output out_imm_j, out_imm_u, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32/64 base-ISA decode stage: field extraction, immediate generation,
// illegal-opcode flagging and a saturating illegal counter.
// Define DECODE_STAGE_SKID_EN for a 2-entry skid buffer with in_ready driven
// from state only; otherwise a single output register with pass-through ready.
module decode_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ILLEGAL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  decode_stage_if.slave            bus,
  output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic            illegal;
  } dec_t;

  dec_t       dec_c;
  dec_t       out_q;
  dec_t       out_d;
  logic       out_valid_q;
  logic       out_valid_d;
  logic       opc_known;
  logic       in_fire;
  logic       out_fire;
  logic [31:0] ins;

  assign ins = bus.in_instr;

  // Combinational decode of the incoming word; illegal words still decode fully.
  always_comb begin
    dec_c        = '0;
    opc_known    = 1'b0;
    dec_c.pc     = bus.in_pc;
    dec_c.op     = ins[6:0];
    dec_c.rd     = ins[11:7];
    dec_c.funct3 = ins[14:12];
    dec_c.rs1    = ins[19:15];
    dec_c.rs2    = ins[24:20];
    dec_c.funct7 = ins[31:25];
    dec_c.imm_i  = XLEN'($signed(ins[31:20]));
    dec_c.imm_s  = XLEN'($signed({ins[31:25], ins[11:7]}));
    dec_c.imm_b  = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    dec_c.imm_j  = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    dec_c.imm_u  = XLEN'($signed({ins[31:12], 12'b0}));
    case (ins[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: opc_known = 1'b1;
      default:                                      opc_known = 1'b0;
    endcase
    dec_c.illegal = !(opc_known && (ins[1:0] == 2'b11));
  end

  assign out_fire = out_valid_q & bus.out_ready;
  assign in_fire  = bus.in_valid & bus.in_ready;

`ifdef DECODE_STAGE_SKID_EN
  dec_t skid_q;
  dec_t skid_d;
  logic skid_valid_q;
  logic skid_valid_d;

  // Ready depends only on skid occupancy, flush and reset, never on out_ready.
  assign bus.in_ready = rst_n & ~flush & ~skid_valid_q;

  // Output slot refills from the skid first; a stalled output parks input in the skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
  end

  // Skid entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  // Accept whenever the output register is empty or draining this cycle.
  assign bus.in_ready = rst_n & ~flush & (~out_valid_q | bus.out_ready);

  // Single output register: load on input transfer, empty on output transfer.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_d       = dec_c;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Count illegal words accepted downstream, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (out_fire && out_q.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + ILLEGAL_CNT_W'(1);
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_op      = out_q.op;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_funct7  = out_q.funct7;
  assign bus.out_imm_i   = out_q.imm_i;
  assign bus.out_imm_s   = out_q.imm_s;
  assign bus.out_imm_b   = out_q.imm_b;
  assign bus.out_imm_j   = out_q.imm_j;
  assign bus.out_imm_u   = out_q.imm_u;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic s_flush = 1'b0;
  logic [15:0] illegal_cnt;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(64)) b ();
  decode_stage_if #(.XLEN(32)) s ();

  decode_stage #(.XLEN(64), .ILLEGAL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b), .illegal_cnt(illegal_cnt));

  decode_stage #(.XLEN(32), .ILLEGAL_CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .bus(s), .illegal_cnt(s_cnt));

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] ii, is, ib, ij, iu;
    logic        ill;
  } rec_t;

  typedef struct {
    logic [31:0] ins;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  f3;
    logic        ill;
    int          kind;  // 0 I, 1 S, 2 B, 3 J, 4 U
    logic [63:0] imm;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          delivered = 0;
  rec_t        q[$];
  rec_t        prev;
  logic        prev_stall = 1'b0;
  logic [15:0] exp_cnt = '0;
  vec_t        tbl[15];
  logic [6:0]  legal_ops[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input rec_t act, input rec_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference decode from the ISA definition using plain signed arithmetic.
  function automatic rec_t model(input logic [31:0] w, input logic [63:0] pc);
    rec_t   r;
    longint v;
    logic   known;
    v = longint'($signed(w));
    r.pc  = pc;
    r.op  = w[6:0];
    r.rd  = w[11:7];
    r.f3  = w[14:12];
    r.rs1 = w[19:15];
    r.rs2 = w[24:20];
    r.f7  = w[31:25];
    r.ii  = 64'(v >>> 20);
    r.is  = 64'((v >>> 25) * 32 + longint'(w[11:7]));
    r.ib  = 64'((v >>> 31) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                + longint'(w[11:8]) * 2);
    r.ij  = 64'((v >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2);
    r.iu  = 64'((v >>> 12) * 4096);
    known = 1'b0;
    for (int i = 0; i < 11; i++) if (w[6:0] == legal_ops[i]) known = 1'b1;
    r.ill = !(known && w[1:0] == 2'b11);
    return r;
  endfunction

  function automatic rec_t sample();
    rec_t r;
    r.pc = b.out_pc; r.op = b.out_op; r.rd = b.out_rd; r.rs1 = b.out_rs1;
    r.rs2 = b.out_rs2; r.f3 = b.out_funct3; r.f7 = b.out_funct7;
    r.ii = b.out_imm_i; r.is = b.out_imm_s; r.ib = b.out_imm_b;
    r.ij = b.out_imm_j; r.iu = b.out_imm_u; r.ill = b.out_illegal;
    return r;
  endfunction

  // One clock of traffic on the main DUT with scoreboard checks at the falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic rdy, input logic fl, output logic acc);
    rec_t cur, e;
    logic exp_rdy, ofire;
    b.in_valid = v; b.in_instr = ins; b.in_pc = pc; b.out_ready = rdy; flush = fl;
    @(negedge clk);
    cur = sample();
    chk("out_valid", 64'(b.out_valid), 64'(q.size() != 0));
    if (prev_stall) chk_rec("stall_hold", cur, prev);
    chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
`ifdef DECODE_STAGE_SKID_EN
    exp_rdy = !fl && (q.size() < 2);
`else
    exp_rdy = !fl && (q.size() == 0 || rdy);
`endif
    chk("in_ready", 64'(b.in_ready), 64'(exp_rdy));
    ofire = b.out_valid && rdy;
    acc = v && b.in_ready;
    if (ofire) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got pc %h expected no output", cur.pc);
      end else begin
        e = q.pop_front();
        chk_rec("out_seq", cur, e);
        delivered++;
        if (e.ill && exp_cnt != 16'hFFFF) exp_cnt++;
      end
    end
    if (acc && !fl) q.push_back(model(ins, pc));
    if (fl) q.delete();
    prev_stall = b.out_valid && !rdy && !fl;
    prev = cur;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pick_imm(input int kind);
    case (kind)
      0:       return b.out_imm_i;
      1:       return b.out_imm_s;
      2:       return b.out_imm_b;
      3:       return b.out_imm_j;
      default: return b.out_imm_u;
    endcase
  endfunction

  initial begin
    logic acc;
    logic [63:0] ones = '1;
    logic [15:0] cnt_before;
    int idx, k;

    legal_ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    tbl[0]  = '{32'hFFF00093, 7'h13, 5'd1,  5'd0,  3'd0, 1'b0, 0, ones};
    tbl[1]  = '{32'hFE000EE3, 7'h63, 5'd29, 5'd0,  3'd0, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[2]  = '{32'h00000000, 7'h00, 5'd0,  5'd0,  3'd0, 1'b1, 0, 64'h0};
    tbl[3]  = '{32'hFFFFFFFF, 7'h7F, 5'd31, 5'd31, 3'd7, 1'b1, 0, ones};
    tbl[4]  = '{32'h123452B7, 7'h37, 5'd5,  5'd8,  3'd5, 1'b0, 4, 64'h0000_0000_1234_5000};
    tbl[5]  = '{32'h0020A423, 7'h23, 5'd8,  5'd1,  3'd2, 1'b0, 1, 64'h8};
    tbl[6]  = '{32'h0010006F, 7'h6F, 5'd0,  5'd0,  3'd0, 1'b0, 3, 64'h800};
    tbl[7]  = '{32'h0000000B, 7'h0B, 5'd0,  5'd0,  3'd0, 1'b1, 0, 64'h0};
    tbl[8]  = '{32'h00000012, 7'h12, 5'd0,  5'd0,  3'd0, 1'b1, 0, 64'h0};
    tbl[9]  = '{32'h00000073, 7'h73, 5'd0,  5'd0,  3'd0, 1'b0, 0, 64'h0};
    tbl[10] = '{32'h0000000F, 7'h0F, 5'd0,  5'd0,  3'd0, 1'b0, 0, 64'h0};
    tbl[11] = '{32'hFFF00067, 7'h67, 5'd0,  5'd0,  3'd0, 1'b0, 0, ones};
    tbl[12] = '{32'h00000033, 7'h33, 5'd0,  5'd0,  3'd0, 1'b0, 0, 64'h0};
    tbl[13] = '{32'h00000003, 7'h03, 5'd0,  5'd0,  3'd0, 1'b0, 0, 64'h0};
    tbl[14] = '{32'h00000017, 7'h17, 5'd0,  5'd0,  3'd0, 1'b0, 4, 64'h0};

    b.in_valid = 1'b0; b.in_instr = '0; b.in_pc = '0; b.out_ready = 1'b1;
    s.in_valid = 1'b0; s.in_instr = '0; s.in_pc = '0; s.out_ready = 1'b1;

    // Reset state.
    #1;
    chk("rst_out_valid", 64'(b.out_valid), 64'h0);
    chk("rst_in_ready", 64'(b.in_ready), 64'h0);
    chk("rst_cnt", 64'(illegal_cnt), 64'h0);
    chk("rst_out_pc", b.out_pc, 64'h0);
    chk("rst_imm_i", b.out_imm_i, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(b.in_ready), 64'h1);
    @(posedge clk); #1;

    // Two illegal words back to back.
    step(1'b1, 32'h00000000, 64'h10, 1'b1, 1'b0, acc);
    step(1'b1, 32'hFFFFFFFF, 64'h14, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    chk("illegal_cnt_two", 64'(illegal_cnt), 64'd2);

    // Directed vector table, one cycle latency each.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].ins, 64'h8000_0000_0000_0000 + 64'(i * 4), 1'b1, 1'b0, acc);
      chk($sformatf("v%0d_valid", i), 64'(b.out_valid), 64'h1);
      chk($sformatf("v%0d_pc", i), b.out_pc, 64'h8000_0000_0000_0000 + 64'(i * 4));
      chk($sformatf("v%0d_op", i), 64'(b.out_op), 64'(tbl[i].op));
      chk($sformatf("v%0d_rd", i), 64'(b.out_rd), 64'(tbl[i].rd));
      chk($sformatf("v%0d_rs1", i), 64'(b.out_rs1), 64'(tbl[i].rs1));
      chk($sformatf("v%0d_f3", i), 64'(b.out_funct3), 64'(tbl[i].f3));
      chk($sformatf("v%0d_ill", i), 64'(b.out_illegal), 64'(tbl[i].ill));
      chk($sformatf("v%0d_imm", i), pick_imm(tbl[i].kind), tbl[i].imm);
    end
    repeat (2) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Narrow instance: 32-bit immediates and 2-bit saturating counter.
    s.in_valid = 1'b1; s.in_instr = 32'hFFF00093; s.in_pc = 32'h100;
    @(posedge clk); #1;
    chk("s_valid", 64'(s.out_valid), 64'h1);
    chk("s_op", 64'(s.out_op), 64'h13);
    chk("s_rd", 64'(s.out_rd), 64'h1);
    chk("s_imm_i", 64'(s.out_imm_i), 64'hFFFF_FFFF);
    chk("s_ill", 64'(s.out_illegal), 64'h0);
    for (int i = 0; i < 5; i++) begin
      s.in_instr = (i % 2 == 0) ? 32'h0 : 32'hFFFFFFFF;
      @(posedge clk); #1;
    end
    s.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("s_cnt_sat", 64'(s_cnt), 64'h3);

    // Four-instruction stream with downstream stalled on cycles 2-4.
    delivered = 0; idx = 0; k = 1;
    while ((delivered < 4) && (k < 30)) begin
      step(idx < 4, {12'(idx + 1), 5'd0, 3'd0, 5'(idx + 1), 7'h13}, 64'(32'h200 + idx * 4),
           !(k >= 2 && k <= 4), 1'b0, acc);
      if (acc) idx++;
      k++;
    end
    chk("stream_delivered", 64'(delivered), 64'd4);
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Flush while stalled with held illegal words; flush beats a valid input.
    step(1'b1, 32'h0, 64'h300, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0, 64'h304, 1'b0, 1'b0, acc);
    cnt_before = exp_cnt;
    step(1'b1, 32'h00500093, 64'h308, 1'b0, 1'b1, acc);
    chk("flush_out_valid", 64'(b.out_valid), 64'h0);
    chk("flush_cnt", 64'(illegal_cnt), 64'(cnt_before));
    step(1'b1, 32'h00700113, 64'h30C, 1'b1, 1'b0, acc);
    chk("post_flush_valid", 64'(b.out_valid), 64'h1);
    chk("post_flush_op", 64'(b.out_op), 64'h13);
    chk("post_flush_rd", 64'(b.out_rd), 64'h2);
    chk("post_flush_imm", b.out_imm_i, 64'h7);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Randomized traffic with back-pressure and occasional flush.
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = legal_ops[$urandom_range(10)];
      step($urandom_range(3) != 0, w, {$urandom, $urandom}, $urandom_range(9) < 7,
           $urandom_range(39) == 0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
    chk("random_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset while stalled with held illegal words.
    step(1'b1, 32'h0, 64'h400, 1'b0, 1'b0, acc);
    step(1'b1, 32'hFFFFFFFF, 64'h404, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0, 64'h408, 1'b0, 1'b0, acc);
    b.in_valid = 1'b0; b.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(b.out_valid), 64'h0);
    chk("mid_rst_cnt", 64'(illegal_cnt), 64'h0);
    chk("mid_rst_in_ready", 64'(b.in_ready), 64'h0);
    q.delete(); exp_cnt = '0; prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release_ready", 64'(b.in_ready), 64'h1);
    @(posedge clk); #1;
    step(1'b1, 32'hFFF00093, 64'h500, 1'b1, 1'b0, acc);
    chk("after_rst_op", 64'(b.out_op), 64'h13);
    chk("after_rst_imm", b.out_imm_i, ones);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter XLEN, default 32: datapath width; SHALL be 32 or 64; immediates sign-extended to XLEN.
REQ-003 Parameter ILLEGAL_CNT_W, default 16: width of the illegal-instruction counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  discard all held instructions.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  stage can accept an instruction.
REQ-009 in_instr  input  32  raw instruction word.
REQ-010 in_pc  input  XLEN  instruction address.
REQ-011 out_valid  output  1  decoded result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_pc  output  XLEN  registered in_pc.
REQ-014 out_op/out_rd/out_rs1/out_rs2/out_funct3/out_funct7  output  7/5/5/5/3/7  instruction fields.
REQ-015 out_imm_i/out_imm_s/out_imm_b/out_imm_j/out_imm_u  output  XLEN each  sign-extended immediates (B/J with bit0=0, U = instr[31:12]<<12, sign-extended).
REQ-016 out_illegal  output  1  opcode not supported.
REQ-017 illegal_cnt  output  ILLEGAL_CNT_W  saturating count of illegal instructions accepted downstream.

Function
REQ-018 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to out_valid with no stall.
REQ-020 Output SHALL hold all out_* values stable while out_valid=1 and out_ready=0.
REQ-021 out_illegal SHALL be 1 if instr[1:0]!=2'b11 or opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM}.
REQ-022 Illegal instructions SHALL still flow through with all fields decoded; no stall.
REQ-023 illegal_cnt SHALL increment by 1 on each output transfer with out_illegal=1 and hold at all-ones.
REQ-024 flush SHALL clear out_valid (and any skid entry) next cycle; in_ready SHALL be 0 while flush=1; flush wins over a simultaneous input transfer.
REQ-025 Flush SHALL NOT modify illegal_cnt; a flushed instruction SHALL never be counted.
REQ-026 No instruction SHALL be dropped or duplicated under any pattern of in_valid/out_ready.

Reset
REQ-027 On rst_n=0, out_valid, skid-valid and illegal_cnt SHALL clear to 0 asynchronously; all data outputs SHALL reset to 0.
REQ-028 in_ready SHALL be 0 during reset and 1 on the first cycle after deassertion.
REQ-029 Reset mid-stall SHALL discard all held instructions.

Configuration
REQ-030 Macro DECODE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-031 Defined: 2-entry skid; in_ready is a registered signal (no combinational path from out_ready); full throughput with one skid entry absorbing a stall.
REQ-032 Not defined: single output register; in_ready = !out_valid | out_ready (combinational); full throughput, zero extra storage.
REQ-033 Both modes SHALL give identical output sequences for identical stimulus.

Verification
REQ-034 addi x1,x0,-1 (0xFFF00093) -> next cycle out_valid=1, out_op=0x13, out_rd=1, out_imm_i=all-ones, out_illegal=0.
REQ-035 beq x0,x0,-4 (0xFE000EE3), XLEN=64 -> out_imm_b=0xFFFFFFFFFFFFFFFC, out_op=0x63.
REQ-036 0x00000000 then 0xFFFFFFFF, out_ready=1 -> out_illegal=1 both, illegal_cnt=2; with ILLEGAL_CNT_W=2, five illegals -> illegal_cnt=3.
REQ-037 Stream 4 instructions, out_ready=0 for cycles 2-4 -> all 4 delivered in order, outputs stable during stall, none lost (both macro settings).
REQ-038 flush while stalled holding 2 instructions -> out_valid=0 next cycle, illegal_cnt unchanged, next input decoded normally.
REQ-039 rst_n=0 asserted mid-stall -> out_valid=0 and illegal_cnt=0 immediately, no clock edge needed.
